instruction_fetch: RTL and testbench



---
 rtl/rv32_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instruction_fetch.sv | 151 +++++++++++++++
 tb/tb_instruction_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the RV32 front end.
//   fetch_entry_t : fetched word paired with the PC it was fetched from
//   fetch_state_e : fetch sequencer states
//   word_align()  : clears the byte-offset bits of an address
package rv32_pkg;

   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [31:0] ADDR_LSB_MASK = 32'h0000_0003;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_DRAIN
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~ADDR_LSB_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and a head that reads zero when empty.
// Used both for fetched instructions and for the in-order request-PC tags.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   write an entry (ignored when full unless popping too)
//   pop_i            drop the head (ignored when empty)
//   flush_i          empty the FIFO; wins over a same-cycle push/pop
//   head_o           oldest entry, zero while empty
//   count_o          number of stored entries
module fetch_fifo
   import rv32_pkg::*;
#(
   parameter type         T     = fetch_entry_t,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  T              data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output T              head_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned   AW   = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

   T              r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign w_pop  = pop_i && (r_count != '0);
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign w_push = push_i && ((r_count != FULL) || w_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && w_push) r_mem[r_wr] <= data_i;
   end

   assign head_o  = (r_count != '0) ? r_mem[r_rd] : '0;
   assign count_o = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: keeps the PC, issues in-order word requests on
// a req/gnt/rvalid memory port, buffers returned words with their PC and
// presents them on a valid/ready interface. A redirect flushes the buffer and
// drops every response still in flight.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   imem_req_o, imem_addr_o        fetch request and word-aligned address
//   imem_gnt_i                     request accepted this cycle
//   imem_rvalid_i, imem_rdata_i    in-order response
//   redirect_i, redirect_pc_i      control-flow redirect from execute
//   instr_valid_o, instr_raw_o,
//   instr_pc_o, instr_ready_i      instruction stream to the decoder
//
// state   | meaning
// S_BOOT  | first cycle out of reset, no request
// S_FETCH | requests issued while buffer + in-flight has room
// S_DRAIN | after a redirect, waits for stale responses to be dropped
module instruction_fetch
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_raw_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i
);

   localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

   fetch_state_e  r_state;
   fetch_state_e  w_state_next;
   logic [31:0]   r_pc;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] w_discard_next;
   logic [CW-1:0] w_outstanding;
   logic [CW-1:0] w_out_next;
   logic [CW-1:0] w_data_count;
   logic [31:0]   w_tag_pc;
   logic          w_req;
   logic          w_grant;
   logic          w_rsp;
   logic          w_push;
   logic          w_pop;
   fetch_entry_t  w_push_entry;
   fetch_entry_t  w_data_head;

   // Never let in-flight responses exceed the free buffer space, so every
   // response that is kept always has a slot waiting for it.
   assign w_req   = (r_state == S_FETCH) &&
                    (({1'b0, w_outstanding} + {1'b0, w_data_count}) < DEPTH_W);
   assign w_grant = w_req && imem_gnt_i;
   assign w_rsp   = imem_rvalid_i && (w_outstanding != '0);
   assign w_push  = w_rsp && (r_discard == '0) && !redirect_i;
   assign w_pop   = instr_valid_o && instr_ready_i && !redirect_i;

   assign w_push_entry = {w_tag_pc, imem_rdata_i};

   // The tag queue holds the PC of every granted request; its fill level is
   // the outstanding-request count.
   fetch_fifo #(
      .T     (logic [31:0]),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_tag_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_grant),
      .data_i  (r_pc),
      .pop_i   (w_rsp),
      .flush_i (1'b0),
      .head_o  (w_tag_pc),
      .count_o (w_outstanding)
   );

   fetch_fifo #(
      .T     (fetch_entry_t),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_data_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .data_i  (w_push_entry),
      .pop_i   (w_pop),
      .flush_i (redirect_i),
      .head_o  (w_data_head),
      .count_o (w_data_count)
   );

   always_comb begin
      w_out_next = w_outstanding;
      if (w_grant && !w_rsp)      w_out_next = w_outstanding + CW'(1);
      else if (w_rsp && !w_grant) w_out_next = w_outstanding - CW'(1);
   end

   // A redirect writes off everything still in flight after this cycle,
   // including a same-cycle grant; a same-cycle response is already gone.
   always_comb begin
      w_discard_next = r_discard;
      if (redirect_i)                       w_discard_next = w_out_next;
      else if (w_rsp && (r_discard != '0))  w_discard_next = r_discard - CW'(1);
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_BOOT:  w_state_next = S_FETCH;
         S_FETCH: w_state_next = S_FETCH;
         // Leave as the last stale response arrives so fetching resumes
         // on the very next cycle.
         S_DRAIN: if (w_discard_next == '0) w_state_next = S_FETCH;
         default: w_state_next = S_BOOT;
      endcase
      if (redirect_i) begin
         if ((r_state == S_DRAIN) || (w_out_next != '0)) w_state_next = S_DRAIN;
         else                                             w_state_next = S_FETCH;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_BOOT;
         r_pc      <= RESET_PC;
         r_discard <= '0;
      end else begin
         r_state   <= w_state_next;
         r_discard <= w_discard_next;
         if (redirect_i)   r_pc <= word_align(redirect_pc_i);
         else if (w_grant) r_pc <= r_pc + 32'(INSTR_BYTES);
      end
   end

   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_pc;
   assign instr_valid_o = (w_data_count != '0);
   assign instr_raw_o   = w_data_head.instr;
   assign instr_pc_o    = w_data_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
   import rv32_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_raw_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   always #5 clk_i = ~clk_i;

   instruction_fetch #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_raw_o   (instr_raw_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i)
   );

   int           total = 0;
   int           bad   = 0;
   logic [31:0]  pend[$];
   fetch_entry_t exp_q[$];
   int           drop_cnt = 0;
   logic [31:0]  exp_pc   = RST_PC;
   int           n_gnt    = 0;
   logic         rsp_en   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0080) return 32'h0050_0093;
      return {a[15:0], 16'h0013} ^ 32'h1234_0000;
   endfunction

   // One clock: memory model responds, scoreboard pops/pushes, then the edge.
   task automatic tick();
      logic         g;
      fetch_entry_t e;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      if (!rst_i && rsp_en && (pend.size() > 0)) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(pend[0]);
      end
      g = imem_req_o && imem_gnt_i;
      if (!rst_i) begin
         if (instr_valid_o && instr_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) chk("sb_valid_unexpected", instr_valid_o, 1'b0);
            else begin
               e = exp_q.pop_front();
               chk("sb_pc", instr_pc_o, e.pc);
               chk("sb_raw", instr_raw_o, e.instr);
            end
         end
         if (imem_rvalid_i) begin
            e.pc    = pend.pop_front();
            e.instr = imem_rdata_i;
            if (redirect_i)        ;
            else if (drop_cnt > 0) drop_cnt--;
            else                   exp_q.push_back(e);
         end
         if (g) begin
            chk("gnt_addr", imem_addr_o, exp_pc);
            pend.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_gnt++;
         end
         if (redirect_i) begin
            exp_q.delete();
            drop_cnt = pend.size();
            exp_pc   = redirect_pc_i & ~32'h3;
         end
      end
      @(posedge clk_i);
      #1;
      imem_rvalid_i = 1'b0;
      if (rst_i) begin
         pend.delete();
         exp_q.delete();
         drop_cnt = 0;
         exp_pc   = RST_PC;
      end
   endtask

   task automatic do_reset();
      rst_i         = 1'b1;
      imem_gnt_i    = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      instr_ready_i = 1'b0;
      rsp_en        = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic drain();
      redirect_i    = 1'b0;
      imem_gnt_i    = 1'b0;
      instr_ready_i = 1'b1;
      rsp_en        = 1'b1;
      for (int k = 0; k < 20 && (pend.size() > 0 || exp_q.size() > 0 || instr_valid_o); k++) tick();
      chk("drain_left", pend.size() + exp_q.size(), 0);
      chk("drain_valid", instr_valid_o, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      do_reset();
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_valid", instr_valid_o, 1'b0);
      chk("rst_raw", instr_raw_o, 32'h0);
      chk("rst_pc", instr_pc_o, 32'h0);

      // basic flow from reset
      tick();
      chk("t1_req0", imem_req_o, 1'b1);
      chk("t1_addr0", imem_addr_o, 32'h80);
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1; rsp_en = 1'b1;
      tick();
      chk("t1_addr1", imem_addr_o, 32'h84);
      tick();
      chk("t1_valid", instr_valid_o, 1'b1);
      chk("t1_raw", instr_raw_o, 32'h0050_0093);
      chk("t1_pc", instr_pc_o, 32'h80);
      tick();
      chk("t1_req2", imem_req_o, 1'b1);
      chk("t1_addr2", imem_addr_o, 32'h88);
      repeat (6) tick();
      drain();

      // backpressure
      do_reset();
      tick();
      n_gnt = 0;
      imem_gnt_i = 1'b1; rsp_en = 1'b1; instr_ready_i = 1'b0;
      repeat (6) tick();
      chk("bp_ngnt", n_gnt, 2);
      chk("bp_req_low", imem_req_o, 1'b0);
      chk("bp_valid", instr_valid_o, 1'b1);
      instr_ready_i = 1'b1;
      tick();
      instr_ready_i = 1'b0;
      chk("bp_req_resume", imem_req_o, 1'b1);
      chk("bp_addr_resume", imem_addr_o, 32'h88);
      drain();

      // grant stall
      do_reset();
      tick();
      imem_gnt_i = 1'b0; instr_ready_i = 1'b1; rsp_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_req", imem_req_o, 1'b1);
         chk("stall_addr", imem_addr_o, 32'h80);
         tick();
      end
      imem_gnt_i = 1'b1;
      tick();
      imem_gnt_i = 1'b0;
      chk("stall_addr_next", imem_addr_o, 32'h84);
      drain();

      // redirect with two requests in flight
      do_reset();
      tick();
      imem_gnt_i = 1'b1; rsp_en = 1'b0; instr_ready_i = 1'b1;
      tick();
      tick();
      chk("rd_req_full", imem_req_o, 1'b0);
      imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
      tick();
      redirect_i = 1'b0;
      chk("rd_req_drain0", imem_req_o, 1'b0);
      chk("rd_valid0", instr_valid_o, 1'b0);
      rsp_en = 1'b1; imem_gnt_i = 1'b1;
      tick();
      chk("rd_req_drain1", imem_req_o, 1'b0);
      chk("rd_valid1", instr_valid_o, 1'b0);
      tick();
      chk("rd_req_new", imem_req_o, 1'b1);
      chk("rd_addr_new", imem_addr_o, 32'h200);
      chk("rd_valid2", instr_valid_o, 1'b0);
      drain();

      // redirect coinciding with a grant and a response
      do_reset();
      tick();
      imem_gnt_i = 1'b1; rsp_en = 1'b1; instr_ready_i = 1'b0;
      tick();
      chk("sim_addr", imem_addr_o, 32'h84);
      redirect_i = 1'b1; redirect_pc_i = 32'h302;
      tick();
      redirect_i = 1'b0;
      chk("sim_valid0", instr_valid_o, 1'b0);
      chk("sim_req_drain", imem_req_o, 1'b0);
      tick();
      chk("sim_valid1", instr_valid_o, 1'b0);
      chk("sim_req_new", imem_req_o, 1'b1);
      chk("sim_addr_new", imem_addr_o, 32'h300);
      instr_ready_i = 1'b1;
      repeat (4) tick();
      drain();

      // reset while busy
      do_reset();
      tick();
      imem_gnt_i = 1'b1; rsp_en = 1'b1; instr_ready_i = 1'b0;
      tick();
      tick();
      chk("mr_valid_pre", instr_valid_o, 1'b1);
      chk("mr_req_pre", imem_req_o, 1'b0);
      rst_i = 1'b1; rsp_en = 1'b0; imem_gnt_i = 1'b0;
      tick();
      chk("mr_req", imem_req_o, 1'b0);
      chk("mr_valid", instr_valid_o, 1'b0);
      chk("mr_raw", instr_raw_o, 32'h0);
      chk("mr_pc", instr_pc_o, 32'h0);
      rst_i = 1'b0;
      tick();
      chk("mr_req_new", imem_req_o, 1'b1);
      chk("mr_addr_new", imem_addr_o, RST_PC);
      imem_gnt_i = 1'b1; rsp_en = 1'b1; instr_ready_i = 1'b1;
      repeat (5) tick();
      drain();

      // random traffic with occasional redirects
      do_reset();
      tick();
      for (int c = 0; c < 400; c++) begin
         imem_gnt_i    = ($urandom_range(0, 3) != 0);
         instr_ready_i = ($urandom_range(0, 3) != 0);
         rsp_en        = ($urandom_range(0, 2) != 0);
         redirect_i    = ($urandom_range(0, 19) == 0);
         redirect_pc_i = $urandom();
         tick();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
